// File: rtl/po2_pkg.sv
// Shared types and helpers for the po2 dot-product datapath.
// Helpers work on 64-bit containers so one definition serves every W/N
// combination; callers cast the result down to their accumulator width.
package po2_pkg;

  // Controller states
  localparam logic [1:0] StWait   = 2'd0;
  localparam logic [1:0] StAccum  = 2'd1;
  localparam logic [1:0] StNarrow = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  // Accumulator width: double-width product plus guard bits
  function automatic int unsigned calc_aw(input int unsigned w, input int unsigned g);
    return 2 * w + g;
  endfunction

  // Fraction bits of a single-width element
  function automatic int unsigned calc_frac(input int unsigned w, input int unsigned i);
    return w - i;
  endfunction

  // Sign-extend a pw-bit value held in the low bits of a 64-bit container
  function automatic logic [63:0] sext_product(input logic [63:0] p, input int unsigned pw);
    logic [63:0] r;
    r = p;
    for (int b = 0; b < 64; b++) begin
      if (b >= int'(pw)) r[b] = p[pw-1];
    end
    return r;
  endfunction

  // Sign-extend a single-width bias and move its binary point onto the product's
  function automatic logic [63:0] bias_align(input logic [63:0] b, input int unsigned w,
                                             input int unsigned frac);
    return sext_product(b, w) << frac;
  endfunction

endpackage

// File: rtl/fxp_narrow_sat.sv
// Combinational narrowing of a wide accumulator back to single-width Q(I).(W-I).
// Drops FRAC low bits (floor) and saturates when the discarded high bits are not
// a pure sign extension of the kept value.
module fxp_narrow_sat #(
  parameter int unsigned AW   = 35,
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 12
) (
  input  logic [AW-1:0] acc_i,
  output logic [W-1:0]  val_o,
  output logic          sat_o
);

  localparam int unsigned Hi = W + FRAC - 1;

  logic [AW-Hi-1:0] top_bits;
  assign top_bits = acc_i[AW-1:Hi];

  // Clamp to the extreme of the accumulator's sign when the top bits disagree
  always_comb begin
    sat_o = !((&top_bits) || (~|top_bits));
    val_o = acc_i[Hi:FRAC];
    if (sat_o) begin
      val_o = acc_i[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/po2_dot_accumulate.sv
// Serial dot-product accumulator behind a bank of N po2 multipliers.
// Waits for all products valid, adds them one per cycle onto the aligned bias,
// then narrows with saturation and holds the result until in_v drops.
// Optional build macro: PO2_DOT_ACCUMULATE_RELU_EN clamps negative results to 0.
module po2_dot_accumulate
  import po2_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned I = 4,
  parameter int unsigned N = 4,
  parameter int unsigned G = $clog2(N) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*2*W-1:0] in_prod,
  input  logic [N-1:0]   in_v,
  input  logic [W-1:0]   bias,
  output logic [W-1:0]   out,
  output logic           out_v,
  output logic           ovf,
  output logic           busy
);

  localparam int unsigned AW   = calc_aw(W, G);
  localparam int unsigned FRAC = calc_frac(W, I);
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [1:0]      state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [W-1:0]    out_q, out_d;
  logic            out_v_q, out_v_d;
  logic            ovf_q, ovf_d;

  logic [2*W-1:0]  prod_sel;
  logic [W-1:0]    narrow_val;
  logic            narrow_sat;
  logic [W-1:0]    result;

  assign prod_sel = in_prod[int'(idx_q)*2*W +: 2*W];

  fxp_narrow_sat #(
    .AW   (AW),
    .W    (W),
    .FRAC (FRAC)
  ) u_narrow (
    .acc_i (acc_q),
    .val_o (narrow_val),
    .sat_o (narrow_sat)
  );

  // Optional ReLU on the narrowed value; saturation flag is unaffected
  always_comb begin
`ifdef PO2_DOT_ACCUMULATE_RELU_EN
    result = narrow_val[W-1] ? '0 : narrow_val;
`else
    result = narrow_val;
`endif
  end

  // Controller next-state, accumulator and output register updates
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    out_d   = out_q;
    out_v_d = out_v_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StWait: begin
        if (&in_v) begin
          acc_d   = AW'(bias_align(64'(bias), W, FRAC));
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        acc_d = acc_q + AW'(sext_product(64'(prod_sel), 2 * W));
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxW'(N - 1)) state_d = StNarrow;
      end
      StNarrow: begin
        out_d   = result;
        ovf_d   = narrow_sat;
        out_v_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        // Re-arm only once every multiplier has released its valid
        if (in_v == '0) begin
          out_v_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // State registers, asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWait;
      idx_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      out_v_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      out_v_q <= out_v_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out   = out_q;
  assign out_v = out_v_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q == StAccum) || (state_q == StNarrow);

endmodule

// File: tb/tb_po2_dot_accumulate.sv
// Directed self-checking bench for po2_dot_accumulate (W=16, I=4, N=4).
module tb_po2_dot_accumulate;

  logic         clk;
  logic         rst;
  logic [127:0] in_prod;
  logic [3:0]   in_v;
  logic [15:0]  bias;
  logic [15:0]  out;
  logic         out_v;
  logic         ovf;
  logic         busy;

  int checks;
  int failures;

`ifdef PO2_DOT_ACCUMULATE_RELU_EN
  localparam bit Relu = 1'b1;
`else
  localparam bit Relu = 1'b0;
`endif

  po2_dot_accumulate #(
    .W (16),
    .I (4),
    .N (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_prod (in_prod),
    .in_v    (in_v),
    .bias    (bias),
    .out     (out),
    .out_v   (out_v),
    .ovf     (ovf),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a full vector and count edges until out_v rises (-1 on timeout)
  task automatic run_vec(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [15:0] b, output int lat);
    in_prod = {p3, p2, p1, p0};
    bias    = b;
    in_v    = 4'hF;
    lat     = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_v) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  task automatic release_v();
    in_v = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_v = '0; in_prod = '0; bias = '0;
    @(posedge clk); #1;
    checks++;
    if (out !== 16'h0 || out_v !== 1'b0 || ovf !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset: out=%h out_v=%b ovf=%b busy=%b required 0000 0 0 0",
               out, out_v, ovf, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sum();
    int lat;
    run_vec(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 16'h0800, lat);
    checks++;
    if (lat !== 5) begin
      failures++; $display("FAIL sum_latency: got %0d required 5", lat);
    end
    checks++;
    if (out !== 16'h4800 || ovf !== 1'b0) begin
      failures++; $display("FAIL sum: out=%h ovf=%b required 4800 0", out, ovf);
    end
    release_v();
  endtask

  task automatic test_pos_sat();
    int lat;
    run_vec(32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 32'h0400_0000, 16'h0000, lat);
    checks++;
    if (lat !== 5 || out !== 16'h7FFF || ovf !== 1'b1) begin
      failures++;
      $display("FAIL pos_sat: lat=%0d out=%h ovf=%b required 5 7fff 1", lat, out, ovf);
    end
    release_v();
  endtask

  task automatic test_negative();
    int lat;
    logic [15:0] exp_out;
    exp_out = Relu ? 16'h0000 : 16'hC000;
    run_vec(32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 16'h0000, lat);
    checks++;
    if (lat !== 5 || out !== exp_out || ovf !== 1'b0) begin
      failures++;
      $display("FAIL negative: lat=%0d out=%h ovf=%b required 5 %h 0", lat, out, ovf, exp_out);
    end
    release_v();
  endtask

  task automatic test_neg_sat_floor();
    int lat;
    logic [15:0] exp_sat;
    logic [15:0] exp_floor;
    exp_sat   = Relu ? 16'h0000 : 16'h8000;
    exp_floor = Relu ? 16'h0000 : 16'hFFFF;
    run_vec(32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000, 32'hFC00_0000, 16'hF000, lat);
    checks++;
    if (out !== exp_sat || ovf !== 1'b1) begin
      failures++;
      $display("FAIL neg_sat: out=%h ovf=%b required %h 1", out, ovf, exp_sat);
    end
    release_v();
    run_vec(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 16'h0000, lat);
    checks++;
    if (out !== exp_floor || ovf !== 1'b0) begin
      failures++;
      $display("FAIL floor: out=%h ovf=%b required %h 0", out, ovf, exp_floor);
    end
    release_v();
  endtask

  task automatic test_handshake();
    int lat;
    int busy_seen;
    in_prod = {4{32'h0100_0000}};
    bias    = 16'h0800;
    busy_seen = 0;
    in_v = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (busy || out_v) busy_seen++;
    end
    in_v = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (busy || out_v) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      failures++; $display("FAIL partial_valid: busy/out_v cycles=%0d required 0", busy_seen);
    end
    run_vec(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 16'h0800, lat);
    checks++;
    if (lat !== 5 || out !== 16'h4800) begin
      failures++; $display("FAIL full_valid: lat=%0d out=%h required 5 4800", lat, out);
    end
    // Holding all-valid must not restart accumulation
    busy_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (busy || !out_v) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin
      failures++; $display("FAIL hold_done: bad cycles=%0d required 0", busy_seen);
    end
    release_v();
    checks++;
    if (out_v !== 1'b0 || ovf !== 1'b0 || out !== 16'h4800) begin
      failures++;
      $display("FAIL rearm: out_v=%b ovf=%b out=%h required 0 0 4800", out_v, ovf, out);
    end
    run_vec(32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0, 16'h0000, lat);
    checks++;
    if (lat !== 5 || out !== 16'h2000) begin
      failures++; $display("FAIL fresh_result: lat=%0d out=%h required 5 2000", lat, out);
    end
    release_v();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_prod = {4{32'h0100_0000}};
    bias    = 16'h0800;
    in_v    = 4'hF;
    @(posedge clk); #1;  // edge k
    @(posedge clk); #1;  // edge k+1
    rst = 1'b1;          // asserted before edge k+2
    @(posedge clk); #1;
    checks++;
    if (out_v !== 1'b0 || out !== 16'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: out_v=%b out=%h busy=%b required 0 0000 0", out_v, out, busy);
    end
    rst = 1'b0;
    run_vec(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 16'h0800, lat);
    checks++;
    if (lat !== 5 || out !== 16'h4800 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL after_reset: lat=%0d out=%h ovf=%b required 5 4800 0", lat, out, ovf);
    end
    release_v();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sum();
    test_pos_sat();
    test_negative();
    test_neg_sat_floor();
    test_handshake();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
